// File: rtl/trb_pkg.sv
// Shared types and width helpers for the turbo input demux.
// Contents:
//   trb_state_e  - dispatcher state: IDLE (waiting for a frame start) or STREAM
//   min1_clog2   - ceil(log2(n)) clamped to at least 1, so single-lane or
//                  single-beat builds still get a legal vector width
package trb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } trb_state_e;

    function automatic int min1_clog2(input int n);
        int w;
        w = (n <= 1) ? 1 : $clog2(n);
        return w;
    endfunction

endpackage

// File: rtl/trb_rr_pick.sv
// Round-robin lane picker: scans ready_i starting at lane ptr_i, wrapping
// once around the lane set, and reports the first ready lane.
// Ports:
//   ready_i  in   NUM_TURBO  per-lane ready
//   ptr_i    in   LANE_W     lane to start the search from
//   sel_o    out  LANE_W     first ready lane at or after ptr_i (cyclic)
//   any_o    out  1          at least one lane is ready
module trb_rr_pick
    import trb_pkg::*;
#(
    parameter int NUM_TURBO = 2,
    parameter int LANE_W    = 1
) (
    input  logic [NUM_TURBO-1:0] ready_i,
    input  logic [LANE_W-1:0]    ptr_i,
    output logic [LANE_W-1:0]    sel_o,
    output logic                 any_o
);

    // One extra bit holds ptr + offset before the modulo fold.
    logic [LANE_W:0]   sum_s;
    logic [LANE_W-1:0] idx_s;

    // Cyclic first-set search; the first hit latches and later hits are ignored.
    always_comb begin
        sel_o = {LANE_W{1'b0}};
        any_o = 1'b0;
        sum_s = {(LANE_W+1){1'b0}};
        idx_s = {LANE_W{1'b0}};
        for (int k = 0; k < NUM_TURBO; k++) begin
            sum_s = {1'b0, ptr_i} + (LANE_W+1)'(k);
            idx_s = (sum_s >= (LANE_W+1)'(NUM_TURBO))
                  ? LANE_W'(sum_s - (LANE_W+1)'(NUM_TURBO))
                  : sum_s[LANE_W-1:0];
            if (!any_o && ready_i[idx_s]) begin
                sel_o = idx_s;
                any_o = 1'b1;
            end else begin
                sel_o = sel_o;
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/trb_in_demux.sv
// Frame-level demux: distributes whole FRAME_LEN-beat frames from one
// Avalon-ST input to NUM_TURBO decoder lanes in round-robin order, skipping
// lanes that are not ready when a frame starts. Lane sop/eop are rebuilt
// from the beat counter so each lane always sees exactly FRAME_LEN beats.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   st_data_in     in   DATA_W            input beat data
//   st_valid_in    in   1                 input beat valid
//   st_sop_in      in   1                 input start of frame
//   st_eop_in      in   1                 input end of frame
//   st_ready_out   out  1                 input beat accepted (ready latency 0)
//   st_data_out    out  NUM_TURBO*DATA_W  output data, same register on every lane
//   st_valid_out   out  NUM_TURBO         per-lane valid (one-hot or zero)
//   st_sop_out     out  NUM_TURBO         per-lane sop
//   st_eop_out     out  NUM_TURBO         per-lane eop
//   st_ready_in    in   NUM_TURBO         per-lane ready (ready latency 0)
//   busy           out  1                 a frame is being streamed
//   frame_cnt      out  16                frames dispatched (wraps)
//   err_no_sop     out  1                 pulse: beat dropped in IDLE without sop
//   err_sop        out  1                 pulse: sop seen mid-frame
//   err_len        out  1                 pulse: eop early, or missing on last beat
module trb_in_demux
    import trb_pkg::*;
#(
    parameter int NUM_TURBO = 2,
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 128
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             st_data_in,
    input  logic                          st_valid_in,
    input  logic                          st_sop_in,
    input  logic                          st_eop_in,
    output logic                          st_ready_out,
    output logic [NUM_TURBO*DATA_W-1:0]   st_data_out,
    output logic [NUM_TURBO-1:0]          st_valid_out,
    output logic [NUM_TURBO-1:0]          st_sop_out,
    output logic [NUM_TURBO-1:0]          st_eop_out,
    input  logic [NUM_TURBO-1:0]          st_ready_in,
    output logic                          busy,
    output logic [15:0]                   frame_cnt,
    output logic                          err_no_sop,
    output logic                          err_sop,
    output logic                          err_len
);

    localparam int LANE_W = min1_clog2(NUM_TURBO);
    localparam int CNT_W  = min1_clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(FRAME_LEN - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_TURBO - 1);

    trb_state_e           state_q,      state_d;
    logic [LANE_W-1:0]    rr_ptr_q,     rr_ptr_d;
    logic [LANE_W-1:0]    sel_q,        sel_d;
    logic [LANE_W-1:0]    out_lane_q,   out_lane_d;
    logic [CNT_W-1:0]     beat_cnt_q,   beat_cnt_d;
    logic [DATA_W-1:0]    data_q,       data_d;
    logic [NUM_TURBO-1:0] valid_q,      valid_d;
    logic [NUM_TURBO-1:0] sop_q,        sop_d;
    logic [NUM_TURBO-1:0] eop_q,        eop_d;
    logic [15:0]          frame_cnt_q,  frame_cnt_d;
    logic                 err_no_sop_q, err_no_sop_d;
    logic                 err_sop_q,    err_sop_d;
    logic                 err_len_q,    err_len_d;

    logic                 ov_s;
    logic                 can_load_s;
    logic                 ready_s;
    logic                 accept_s;
    logic                 first_beat_s;
    logic                 last_beat_s;
    logic [LANE_W-1:0]    pick_sel_s;
    logic                 pick_any_s;
    logic [NUM_TURBO-1:0] sel_onehot_s;

    trb_rr_pick #(
        .NUM_TURBO (NUM_TURBO),
        .LANE_W    (LANE_W)
    ) u_pick (
        .ready_i (st_ready_in),
        .ptr_i   (rr_ptr_q),
        .sel_o   (pick_sel_s),
        .any_o   (pick_any_s)
    );

    // The output register can take a new beat if it is empty or draining this cycle.
    assign ov_s         = |valid_q;
    assign can_load_s   = !ov_s || st_ready_in[out_lane_q];
    assign accept_s     = st_valid_in && ready_s;
    assign first_beat_s = (beat_cnt_q == {CNT_W{1'b0}});
    assign last_beat_s  = (beat_cnt_q == LAST_BEAT);

    // Input ready: stream with room in the output register, or drop stray beats in IDLE.
    always_comb begin
        ready_s = 1'b0;
        if (!rst_n) begin
            ready_s = 1'b0;
        end else begin
            case (state_q)
                IDLE:    ready_s = st_valid_in && !st_sop_in;
                STREAM:  ready_s = can_load_s;
                default: ready_s = 1'b0;
            endcase
        end
    end

    // One-hot decode of the lane owning the current frame.
    always_comb begin
        sel_onehot_s = {NUM_TURBO{1'b0}};
        for (int i = 0; i < NUM_TURBO; i++) begin
            sel_onehot_s[i] = (sel_q == LANE_W'(i));
        end
    end

    // Next-state logic for the FSM, beat counter and output register.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        sel_d        = sel_q;
        out_lane_d   = out_lane_q;
        beat_cnt_d   = beat_cnt_q;
        data_d       = data_q;
        valid_d      = valid_q;
        sop_d        = sop_q;
        eop_d        = eop_q;
        frame_cnt_d  = frame_cnt_q;
        err_no_sop_d = 1'b0;
        err_sop_d    = 1'b0;
        err_len_d    = 1'b0;

        // Drain first; a load in the same cycle below overrides it.
        if (ov_s && st_ready_in[out_lane_q]) begin
            valid_d = {NUM_TURBO{1'b0}};
            sop_d   = {NUM_TURBO{1'b0}};
            eop_d   = {NUM_TURBO{1'b0}};
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            IDLE: begin
                if (st_valid_in && !st_sop_in) begin
                    err_no_sop_d = 1'b1;
                end else if (st_valid_in && pick_any_s) begin
                    // Lane is fixed here for the whole frame; the sop beat
                    // itself is taken on the next cycle.
                    sel_d   = pick_sel_s;
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (accept_s) begin
                    data_d     = st_data_in;
                    valid_d    = sel_onehot_s;
                    sop_d      = first_beat_s ? sel_onehot_s : {NUM_TURBO{1'b0}};
                    eop_d      = last_beat_s  ? sel_onehot_s : {NUM_TURBO{1'b0}};
                    out_lane_d = sel_q;
                    err_sop_d  = st_sop_in && !first_beat_s;
                    err_len_d  = last_beat_s ? !st_eop_in : st_eop_in;
                    if (last_beat_s) begin
                        beat_cnt_d  = {CNT_W{1'b0}};
                        rr_ptr_d    = (sel_q == LAST_LANE) ? {LANE_W{1'b0}} : sel_q + LANE_W'(1);
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = IDLE;
                    end else begin
                        beat_cnt_d  = beat_cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = STREAM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= {LANE_W{1'b0}};
            sel_q        <= {LANE_W{1'b0}};
            out_lane_q   <= {LANE_W{1'b0}};
            beat_cnt_q   <= {CNT_W{1'b0}};
            data_q       <= {DATA_W{1'b0}};
            valid_q      <= {NUM_TURBO{1'b0}};
            sop_q        <= {NUM_TURBO{1'b0}};
            eop_q        <= {NUM_TURBO{1'b0}};
            frame_cnt_q  <= 16'd0;
            err_no_sop_q <= 1'b0;
            err_sop_q    <= 1'b0;
            err_len_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            sel_q        <= sel_d;
            out_lane_q   <= out_lane_d;
            beat_cnt_q   <= beat_cnt_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            frame_cnt_q  <= frame_cnt_d;
            err_no_sop_q <= err_no_sop_d;
            err_sop_q    <= err_sop_d;
            err_len_q    <= err_len_d;
        end
    end

    assign st_ready_out = ready_s;
    assign st_data_out  = {NUM_TURBO{data_q}};
    assign st_valid_out = valid_q;
    assign st_sop_out   = sop_q;
    assign st_eop_out   = eop_q;
    assign busy         = (state_q == STREAM);
    assign frame_cnt    = frame_cnt_q;
    assign err_no_sop   = err_no_sop_q;
    assign err_sop      = err_sop_q;
    assign err_len      = err_len_q;

endmodule
